// File: rtl/result_packer.sv
// result_packer: collects the upstream 1-bit result on each falling edge of
// its done strobe, packs PACK_W results LSB-first into words, and buffers the
// completed words in a DEPTH-entry FIFO presented on a valid/ready master
// port. A flush pulse pushes a partially filled word early. Words that arrive
// while the FIFO is full (and not being popped) are dropped and recorded in a
// sticky overflow flag.
module result_packer #(
  parameter int PACK_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             res_bit,
  input  logic                             res_done,
  input  logic                             flush,
  input  logic                             clr_ovf,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [PACK_W-1:0]                m_data,
  output logic [$clog2(PACK_W+1)-1:0]      m_count,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic                             overflow
);

  // Bit index into the word being packed (0..PACK_W-1).
  localparam int IDX_W = $clog2(PACK_W);
  // Count of valid bits carried with each word (1..PACK_W).
  localparam int CNT_W = $clog2(PACK_W + 1);
  // FIFO read/write pointer width; DEPTH is a power of two so pointers wrap.
  localparam int PTR_W = $clog2(DEPTH);
  // FIFO occupancy width (0..DEPTH).
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // ---------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------
  logic done_q;
  logic bit_q;
  logic event_w;

  // Track the done strobe and remember the result bit seen while it is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      done_q <= res_done;
      if (res_done) begin
        bit_q <= res_bit;
      end
    end
  end

  // A result is valid in the cycle after done drops; a long high pulse still
  // produces a single event, and the rising edge produces none.
  assign event_w = done_q & ~res_done;

  // ---------------------------------------------------------------------
  // Packing
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [PACK_W-1:0] shreg_q;
  logic [PACK_W-1:0] shreg_d;
  logic [PACK_W-1:0] shreg_ins;
  logic              push_w;
  logic [PACK_W-1:0] push_data_w;
  logic [CNT_W-1:0]  push_cnt_w;

  // Fold the current event's bit into the word, then decide whether this
  // cycle enqueues it (word complete, or flush with anything to send).
  always_comb begin
    shreg_ins = shreg_q;
    if (event_w) begin
      shreg_ins[idx_q] = bit_q;
    end

    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push_w      = 1'b0;
    push_data_w = shreg_ins;
    // Bits already held plus the one arriving now; equals PACK_W when the
    // event fills the last slot, so completion and flush share one count.
    push_cnt_w  = CNT_W'(idx_q) + CNT_W'(event_w);

    if (flush && (event_w || (idx_q != '0))) begin
      // Flush takes precedence; a word that also completes this cycle is
      // still enqueued exactly once.
      push_w  = 1'b1;
      idx_d   = '0;
      shreg_d = '0;
    end else if (event_w) begin
      if (idx_q == IDX_LAST) begin
        push_w  = 1'b1;
        idx_d   = '0;
        shreg_d = '0;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        shreg_d = shreg_ins;
      end
    end
  end

  // Packing state; the partial word is discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [PACK_W-1:0] mem_data_q [DEPTH];
  logic [CNT_W-1:0]  mem_cnt_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              full_w;
  logic              pop_w;
  logic              wr_en_w;
  logic              drop_w;
  logic [DEPTH-1:0]  wr_sel_w;

  assign full_w  = (level_q == LVL_FULL);
  // m_valid is a decode of the registered level, so an empty pop never fires.
  assign pop_w   = m_valid & m_ready;
  // A pop in the same cycle frees the slot the push needs when full.
  assign wr_en_w = push_w & (~full_w | pop_w);
  assign drop_w  = push_w & full_w & ~pop_w;

  // One-hot write select per entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel_w[gi] = wr_en_w && (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  // Entry storage; only the selected entry is written, so the head stays
  // stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel_w[i]) begin
          mem_data_q[i] <= push_data_w;
          mem_cnt_q[i]  <= push_cnt_w;
        end
      end
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_en_w, pop_w})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A new drop beats a simultaneous clear.
    if (drop_w) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all taken from registers or the FIFO head entry.
  // ---------------------------------------------------------------------
  assign m_valid  = (level_q != '0);
  assign m_data   = mem_data_q[rd_ptr_q];
  assign m_count  = mem_cnt_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed table-driven checks of result_packer plus
// hand-written sequences for overflow, full push/pop, async reset and a
// long done pulse coinciding with flush.
module tb_result_packer;

  logic       clk;
  logic       rst;
  logic       res_bit;
  logic       res_done;
  logic       flush;
  logic       clr_ovf;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] m_count;
  logic [2:0] level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         nbits;
    logic [7:0] bits;
    logic       fl;
    logic [7:0] exp_data;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [8];

  result_packer #(.PACK_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .res_bit  (res_bit),
    .res_done (res_done),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_count  (m_count),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // One done pulse carrying bit b; the E cycle optionally also pops,
  // clears overflow, or flushes.
  task automatic send_bit_ext(input logic b, input logic rdy, input logic clr, input logic fl);
    res_done = 1'b1;
    res_bit  = b;
    tick();
    res_done = 1'b0;
    res_bit  = 1'b0;
    m_ready  = rdy;
    clr_ovf  = clr;
    flush    = fl;
    tick();
    m_ready  = 1'b0;
    clr_ovf  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    send_bit_ext(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
    end
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  // Check the head word and pop it.
  task automatic drain_chk(input string nm, input logic [7:0] w);
    chk({nm, "_valid"}, int'(m_valid), 1);
    chk({nm, "_data"}, int'(m_data), int'(w));
    chk({nm, "_count"}, int'(m_count), 8);
    $display("drain %s data=%h count=%0d level=%0d", nm, m_data, m_count, level);
    pop_one();
  endtask

  logic [7:0] fill_w [4];

  initial begin
    rst      = 1'b0;
    res_bit  = 1'b0;
    res_done = 1'b0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
    m_ready  = 1'b0;

    vecs[0] = '{8, 8'h4D, 1'b0, 8'h4D, 8};
    vecs[1] = '{3, 8'h07, 1'b1, 8'h07, 3};
    vecs[2] = '{8, 8'hFF, 1'b0, 8'hFF, 8};
    vecs[3] = '{8, 8'h00, 1'b0, 8'h00, 8};
    vecs[4] = '{1, 8'h01, 1'b1, 8'h01, 1};
    vecs[5] = '{5, 8'h1A, 1'b1, 8'h1A, 5};
    vecs[6] = '{7, 8'h55, 1'b1, 8'h55, 7};
    vecs[7] = '{8, 8'hA5, 1'b0, 8'hA5, 8};

    // Reset state
    #12;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_count", int'(m_count), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b1;
    tick();

    // Table-driven words
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].nbits; i++) begin
        send_bit(vecs[v].bits[i]);
      end
      if (vecs[v].fl) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      $display("vec %0d data=%h count=%0d level=%0d", v, m_data, m_count, level);
      chk($sformatf("vec%0d_valid", v), int'(m_valid), 1);
      chk($sformatf("vec%0d_data", v), int'(m_data), int'(vecs[v].exp_data));
      chk($sformatf("vec%0d_count", v), int'(m_count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d_level", v), int'(level), 1);
      pop_one();
      chk($sformatf("vec%0d_popped", v), int'(level), 0);
    end

    // Flush with nothing packed: no push
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    $display("empty flush level=%0d valid=%0d", level, m_valid);
    chk("flush0_level", int'(level), 0);
    chk("flush0_valid", int'(m_valid), 0);

    // Overflow: 5 words with consumer stalled
    fill_w[0] = 8'h11; fill_w[1] = 8'h22; fill_w[2] = 8'h33; fill_w[3] = 8'h44;
    for (int k = 0; k < 4; k++) send_word(fill_w[k]);
    send_word(8'h55);
    $display("ovf fill level=%0d overflow=%0d", level, overflow);
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    tick();
    tick();
    chk("ovf_hold_data", int'(m_data), 8'h11);
    for (int k = 0; k < 4; k++) drain_chk($sformatf("ovf_w%0d", k), fill_w[k]);
    chk("ovf_empty", int'(level), 0);
    chk("ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    // Full FIFO, pop and completing word in the same cycle
    fill_w[0] = 8'h21; fill_w[1] = 8'h42; fill_w[2] = 8'h63; fill_w[3] = 8'h84;
    for (int k = 0; k < 4; k++) send_word(fill_w[k]);
    for (int i = 0; i < 7; i++) send_bit(8'hA6 >> i);
    send_bit_ext(1'b1, 1'b1, 1'b0, 1'b0);
    $display("full push+pop level=%0d overflow=%0d head=%h", level, overflow, m_data);
    chk("pp_level", int'(level), 4);
    chk("pp_ovf", int'(overflow), 0);
    drain_chk("pp_w1", 8'h42);
    drain_chk("pp_w2", 8'h63);
    drain_chk("pp_w3", 8'h84);
    drain_chk("pp_w4", 8'hA6);

    // Drop coinciding with clr_ovf: set wins
    fill_w[0] = 8'h0F; fill_w[1] = 8'hF0; fill_w[2] = 8'h3C; fill_w[3] = 8'hC3;
    for (int k = 0; k < 4; k++) send_word(fill_w[k]);
    for (int i = 0; i < 7; i++) send_bit(8'h99 >> i);
    send_bit_ext(1'b1, 1'b0, 1'b1, 1'b0);
    $display("drop+clr level=%0d overflow=%0d", level, overflow);
    chk("dc_ovf", int'(overflow), 1);
    chk("dc_level", int'(level), 4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("dc_clr", int'(overflow), 0);
    for (int k = 0; k < 4; k++) drain_chk($sformatf("dc_w%0d", k), fill_w[k]);

    // Async reset mid-cycle with a queued word and a partial word
    send_word(8'h77);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #3;
    rst = 1'b0;
    #1;
    $display("async reset valid=%0d level=%0d data=%h", m_valid, level, m_data);
    chk("ar_valid", int'(m_valid), 0);
    chk("ar_level", int'(level), 0);
    chk("ar_data", int'(m_data), 0);
    chk("ar_count", int'(m_count), 0);
    #2;
    rst = 1'b1;
    tick();
    send_word(8'hC3);
    $display("post reset data=%h count=%0d level=%0d", m_data, m_count, level);
    chk("ar_new_level", int'(level), 1);
    drain_chk("ar_new", 8'hC3);

    // Long done pulse, then flush in the E cycle at idx=7
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    res_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_bit = (i % 2 == 1);
      tick();
    end
    res_done = 1'b0;
    res_bit  = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    tick();
    $display("long done+flush data=%h count=%0d level=%0d", m_data, m_count, level);
    chk("ld_level", int'(level), 1);
    drain_chk("ld_w", 8'h80);
    chk("ld_empty", int'(m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
